// File: rtl/rdm_pkg.sv
// Shared constants and FSM state type for the RDM input buffer write side.
package rdm_pkg;

    localparam int unsigned LLR_W         = 6;
    localparam int unsigned LLRS_PER_WORD = 16;
    localparam int unsigned WORD_W        = LLR_W * LLRS_PER_WORD;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFlush,
        StHandoff
    } rdm_wr_state_t;

endpackage

// File: rtl/rdm_input_buffer_writer_if.sv
// LLR stream, buffer write port and reader handshake of the RDM input buffer writer.
interface rdm_input_buffer_writer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned E_W    = 14
);
    import rdm_pkg::*;

    logic                  i_Block_Start;
    logic [E_W-1:0]        i_Current_Combine_E01_Size;
    logic                  i_LLR_Valid;
    logic [LLR_W-1:0]      i_LLR_Data;
    logic                  o_LLR_Ready;
    logic                  o_Input_Buffer_Write_Enable;
    logic [ADDR_W-1:0]     o_Input_Buffer_Write_Address;
    logic [WORD_W-1:0]     o_Input_Buffer_Write_Data;
    logic                  o_Combine_process_request;
    logic                  i_RDM_Done;
    logic                  o_Busy;

    modport slave (
        input  i_Block_Start, i_Current_Combine_E01_Size, i_LLR_Valid, i_LLR_Data, i_RDM_Done,
        output o_LLR_Ready, o_Input_Buffer_Write_Enable, o_Input_Buffer_Write_Address,
        output o_Input_Buffer_Write_Data, o_Combine_process_request, o_Busy
    );

    modport master (
        output i_Block_Start, i_Current_Combine_E01_Size, i_LLR_Valid, i_LLR_Data, i_RDM_Done,
        input  o_LLR_Ready, o_Input_Buffer_Write_Enable, o_Input_Buffer_Write_Address,
        input  o_Input_Buffer_Write_Data, o_Combine_process_request, o_Busy
    );

endinterface

// File: rtl/rdm_llr_packer.sv
// Packs LLRs into buffer words, lane 0 at the LSB.
// RDM_WR_ZERO_PAD_EN: clear the packing register after each write.
module rdm_llr_packer import rdm_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load,
    input  logic              flush_wr,
    input  logic [LLR_W-1:0]  llr,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    localparam int unsigned LaneW = $clog2(LLRS_PER_WORD);

    logic [LaneW-1:0]  lane_q;
    logic [WORD_W-1:0] word_q, word_d;

    assign word_full = load && (lane_q == LaneW'(LLRS_PER_WORD - 1));
    assign word      = word_q;

    always_comb begin
        word_d = word_q;
`ifdef RDM_WR_ZERO_PAD_EN
        // A load in the write cycle lands on lane 0 of the freshly cleared word.
        if (flush_wr) word_d = '0;
`endif
        if (load) word_d[LLR_W*lane_q +: LLR_W] = llr;
    end

`ifndef RDM_WR_ZERO_PAD_EN
    logic unused_flush_wr;
    assign unused_flush_wr = flush_wr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            word_q <= word_d;
            if (start || word_full) lane_q <= '0;
            else if (load)          lane_q <= lane_q + 1'b1;
        end
    end

endmodule

// File: rtl/rdm_input_buffer_writer.sv
// Write side of the RDM input buffer: packs one code block of LLRs and hands it to the reader.
// Optional RDM_WR_ZERO_PAD_EN zero-fills unused lanes of a partial last word.
module rdm_input_buffer_writer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned E_W    = 14
) (
    input logic                      i_core_clk,
    input logic                      i_rx_rst,
    rdm_input_buffer_writer_if.slave bus
);
    import rdm_pkg::*;

    rdm_wr_state_t     state_q, state_d;
    logic [E_W-1:0]    e_q;
    logic [E_W:0]      llr_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              start_ok, accept, last_llr, word_full;
    logic [WORD_W-1:0] word;

    assign start_ok = (state_q == StIdle) && bus.i_Block_Start;
    assign accept   = (state_q == StFill) && bus.i_LLR_Valid;
    assign last_llr = accept && ((llr_cnt_q + (E_W+1)'(1)) == {1'b0, e_q});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_ok && (bus.i_Current_Combine_E01_Size != '0)) state_d = StFill;
            StFill:    if (last_llr) state_d = StFlush;
            StFlush:   state_d = StHandoff;
            StHandoff: if (bus.i_RDM_Done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q   <= StIdle;
            e_q       <= '0;
            llr_cnt_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // The last LLR forces a write whether or not its word is full.
            we_q    <= accept && (word_full || last_llr);
            if (start_ok) begin
                e_q       <= bus.i_Current_Combine_E01_Size;
                llr_cnt_q <= '0;
            end else if (accept) begin
                llr_cnt_q <= llr_cnt_q + 1'b1;
            end
            if (start_ok)  addr_q <= '0;
            else if (we_q) addr_q <= addr_q + 1'b1;
        end
    end

    rdm_llr_packer u_packer (
        .clk       (i_core_clk),
        .rst       (i_rx_rst),
        .start     (start_ok),
        .load      (accept),
        .flush_wr  (we_q),
        .llr       (bus.i_LLR_Data),
        .word      (word),
        .word_full (word_full)
    );

    assign bus.o_LLR_Ready                  = (state_q == StFill);
    assign bus.o_Busy                       = (state_q != StIdle);
    assign bus.o_Combine_process_request    = (state_q == StHandoff);
    assign bus.o_Input_Buffer_Write_Enable  = we_q;
    assign bus.o_Input_Buffer_Write_Address = addr_q;
    assign bus.o_Input_Buffer_Write_Data    = word;

endmodule

// File: tb/tb_rdm_input_buffer_writer.sv
// Directed + randomized bench for rdm_input_buffer_writer against a lane-array model.
module tb_rdm_input_buffer_writer;
    import rdm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rdm_input_buffer_writer_if #(.ADDR_W(16), .E_W(14)) bus ();

    rdm_input_buffer_writer #(.ADDR_W(16), .E_W(14)) dut (
        .i_core_clk (clk),
        .i_rx_rst   (rst),
        .bus        (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model of the 16 buffer lanes as last written by the stream.
    logic [5:0] mlanes [16];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] pack_lanes();
        logic [95:0] r = '0;
        for (int j = 0; j < 16; j++) r[6*j +: 6] = mlanes[j];
        return r;
    endfunction

    task automatic clear_lanes();
        for (int j = 0; j < 16; j++) mlanes[j] = 6'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 96'(bus.o_LLR_Ready), 96'd0);
        check({tag, "_we"},    96'(bus.o_Input_Buffer_Write_Enable), 96'd0);
        check({tag, "_req"},   96'(bus.o_Combine_process_request), 96'd0);
        check({tag, "_busy"},  96'(bus.o_Busy), 96'd0);
        check({tag, "_addr"},  96'(bus.o_Input_Buffer_Write_Address), 96'd0);
        check({tag, "_data"},  bus.o_Input_Buffer_Write_Data, 96'd0);
    endtask

    // vmode: 0 continuous, 1 toggling, 2 random. dmode: 0 k mod 64, 1 random.
    task automatic run_block(input int e, input int vmode, input int dmode, input int hold,
                             input int rst_at, input bit late_start);
        logic [5:0] llr [$];
        int k = 0;
        int w = 0;
        int cyc = 0;
        int budget;
        bit v;
        for (int i = 0; i < e; i++) llr.push_back(dmode == 0 ? 6'(i % 64) : 6'($urandom));

        bus.i_Current_Combine_E01_Size = 14'(e);
        bus.i_Block_Start = 1'b1;
        tick();
        bus.i_Block_Start = 1'b0;

        if (e == 0) begin
            for (int c = 0; c < 4; c++) begin
                check("e0_busy",  96'(bus.o_Busy), 96'd0);
                check("e0_we",    96'(bus.o_Input_Buffer_Write_Enable), 96'd0);
                check("e0_req",   96'(bus.o_Combine_process_request), 96'd0);
                check("e0_ready", 96'(bus.o_LLR_Ready), 96'd0);
                tick();
            end
            return;
        end

        budget = 4 * e + 20;
        while (k < e && budget > 0) begin
            budget--;
            if (k == rst_at) begin
                rst = 1'b1;
                bus.i_LLR_Valid = 1'b0;
                tick();
                rst = 1'b0;
                clear_lanes();
                check_all_zero("midrst");
                return;
            end
            check("ready", 96'(bus.o_LLR_Ready), 96'd1);
            check("busy",  96'(bus.o_Busy), 96'd1);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom % 2);
            endcase
            cyc++;
            bus.i_LLR_Valid = v;
            bus.i_LLR_Data  = v ? llr[k] : 6'($urandom);
            tick();
            if (v) begin
                mlanes[k % 16] = llr[k];
                k++;
            end
            if (v && ((k % 16) == 0 || k == e)) begin
                check("we",   96'(bus.o_Input_Buffer_Write_Enable), 96'd1);
                check("addr", 96'(bus.o_Input_Buffer_Write_Address), 96'(w));
                check("data", bus.o_Input_Buffer_Write_Data, pack_lanes());
`ifdef RDM_WR_ZERO_PAD_EN
                clear_lanes();
`endif
                w++;
            end else begin
                check("we_idle", 96'(bus.o_Input_Buffer_Write_Enable), 96'd0);
            end
        end
        if (k < e) begin
            check("stream_timeout", 96'(k), 96'(e));
            bus.i_LLR_Valid = 1'b0;
            return;
        end

        // Flush cycle: ready already low, stray valid must be ignored.
        check("ready_drop", 96'(bus.o_LLR_Ready), 96'd0);
        check("req_early",  96'(bus.o_Combine_process_request), 96'd0);
        bus.i_LLR_Valid = 1'b1;
        bus.i_LLR_Data  = 6'($urandom);
        tick();
        bus.i_LLR_Valid = 1'b0;
        check("req_rise",   96'(bus.o_Combine_process_request), 96'd1);
        check("ho_busy",    96'(bus.o_Busy), 96'd1);
        check("ho_we",      96'(bus.o_Input_Buffer_Write_Enable), 96'd0);

        for (int h = 0; h < hold; h++) begin
            if (late_start && h == hold / 2) begin
                bus.i_Current_Combine_E01_Size = 14'd8;
                bus.i_Block_Start = 1'b1;
            end
            tick();
            bus.i_Block_Start = 1'b0;
            check("req_hold",   96'(bus.o_Combine_process_request), 96'd1);
            check("hold_ready", 96'(bus.o_LLR_Ready), 96'd0);
        end

        bus.i_RDM_Done = 1'b1;
        tick();
        bus.i_RDM_Done = 1'b0;
        check("req_fall",  96'(bus.o_Combine_process_request), 96'd0);
        check("idle_busy", 96'(bus.o_Busy), 96'd0);
    endtask

    initial begin
        bus.i_Block_Start              = 1'b0;
        bus.i_Current_Combine_E01_Size = '0;
        bus.i_LLR_Valid                = 1'b0;
        bus.i_LLR_Data                 = '0;
        bus.i_RDM_Done                 = 1'b0;
        clear_lanes();

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Valid and done outside their states are ignored.
        for (int c = 0; c < 4; c++) begin
            bus.i_LLR_Valid = 1'b1;
            bus.i_LLR_Data  = 6'($urandom);
            bus.i_RDM_Done  = 1'b1;
            tick();
            check("idle_we",    96'(bus.o_Input_Buffer_Write_Enable), 96'd0);
            check("idle_ready", 96'(bus.o_LLR_Ready), 96'd0);
            check("idle_req",   96'(bus.o_Combine_process_request), 96'd0);
        end
        bus.i_LLR_Valid = 1'b0;
        bus.i_RDM_Done  = 1'b0;

        run_block(129, 0, 0, 3,  -1, 1'b0);
        run_block(16,  0, 0, 2,  -1, 1'b0);
        run_block(0,   0, 0, 0,  -1, 1'b0);
        run_block(40,  1, 1, 50, -1, 1'b1);
        run_block(8,   2, 1, 1,  -1, 1'b0);
        run_block(129, 0, 0, 1,  20, 1'b0);
        run_block(16,  2, 1, 1,  -1, 1'b0);
        for (int i = 0; i < 4; i++) run_block(int'($urandom_range(1, 70)), 2, 1, 2, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
